// File: rtl/outcond_pkg.sv
// +----------------------------------------------------------------------------+
// | outcond_pkg                                                                |
// | Shared state encodings, default parameters and request record for the     |
// | output conditioner.                                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package outcond_pkg;

    localparam int c_def_counterwidth = 3;
    localparam int c_def_holdtime     = 3;
    localparam int c_def_pulsewidth   = 4;

    localparam logic [1:0] c_st_stable = 2'd0;
    localparam logic [1:0] c_st_hold   = 2'd1;
`ifdef OUTCOND_PULSE_EN
    localparam logic [1:0] c_st_pulse  = 2'd2;
`endif

    typedef struct packed {
`ifdef OUTCOND_PULSE_EN
        logic pulse;
`endif
        logic level;
    } req_t;

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// +----------------------------------------------------------------------------+
// | dwell_timer                                                                |
// | Loadable up-counter with clear; done flags when the count meets target.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dwell_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_target,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Load starts at 1 because the load cycle itself is the first dwell cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= WIDTH'(1);
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_done = (r_count == i_target);

endmodule

`default_nettype wire

// File: rtl/output_conditioner.sv
// +----------------------------------------------------------------------------+
// | output_conditioner                                                         |
// | Registered output pin with minimum dwell, edge pulses and a one-entry      |
// | pending request buffer. OUTCOND_PULSE_EN adds the auto-pulse request.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module output_conditioner
    import outcond_pkg::*;
#(
    parameter int COUNTERWIDTH = c_def_counterwidth,
    parameter int HOLDTIME     = c_def_holdtime,
    parameter int PULSEWIDTH   = c_def_pulsewidth
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic pinout,
    output logic positiveedge,
    output logic negativeedge,
    output logic busy
`ifdef OUTCOND_PULSE_EN
    ,
    input  logic pulse_req
`endif
);

    localparam logic [COUNTERWIDTH-1:0] c_hold  = COUNTERWIDTH'(HOLDTIME);
    localparam logic [COUNTERWIDTH-1:0] c_pulse = COUNTERWIDTH'(PULSEWIDTH);

    logic [1:0] r_state, w_state_nx;
    logic       r_pin, w_pin_nx;
    logic       r_pos, w_pos_nx;
    logic       r_neg, w_neg_nx;
    logic       r_pend_valid, w_pend_valid_nx;
    req_t       r_pend, w_pend_nx;

    logic       w_accept;
    req_t       w_acc_req;
    req_t       w_src;
    logic       w_do_apply;

    logic                    w_tmr_clear, w_tmr_load, w_tmr_en, w_tmr_done;
    logic [COUNTERWIDTH-1:0] w_tmr_target;

    assign req_ready       = !r_pend_valid;
    assign w_acc_req.level = req_level;
`ifdef OUTCOND_PULSE_EN
    assign w_acc_req.pulse = pulse_req;
    assign w_accept        = req_ready && (req_valid || pulse_req);
    assign w_tmr_target    = (r_state == c_st_pulse) ? c_pulse : c_hold;
`else
    logic w_unused_pulsewidth;
    assign w_unused_pulsewidth = ^c_pulse;
    assign w_accept            = req_ready && req_valid;
    assign w_tmr_target        = c_hold;
`endif

    dwell_timer #(
        .WIDTH (COUNTERWIDTH)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_tmr_clear),
        .i_load   (w_tmr_load),
        .i_en     (w_tmr_en),
        .i_target (w_tmr_target),
        .o_done   (w_tmr_done)
    );

    always_comb begin
        w_state_nx      = r_state;
        w_pin_nx        = r_pin;
        w_pos_nx        = 1'b0;
        w_neg_nx        = 1'b0;
        w_pend_valid_nx = r_pend_valid;
        w_pend_nx       = r_pend;
        w_tmr_clear     = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_en        = 1'b0;
        w_do_apply      = 1'b0;
        w_src           = w_acc_req;

        case (r_state)
            c_st_hold: begin
                if (w_tmr_done) begin
                    if (r_pend_valid) begin
                        w_do_apply      = 1'b1;
                        w_src           = r_pend;
                        w_pend_valid_nx = 1'b0;
                    end else if (w_accept) begin
                        w_do_apply = 1'b1;
                    end else begin
                        w_state_nx  = c_st_stable;
                        w_tmr_clear = 1'b1;
                    end
                end else begin
                    w_tmr_en = 1'b1;
                    if (w_accept) begin
                        w_pend_valid_nx = 1'b1;
                        w_pend_nx       = w_acc_req;
                    end
                end
            end
`ifdef OUTCOND_PULSE_EN
            c_st_pulse: begin
                if (w_accept) begin
                    w_pend_valid_nx = 1'b1;
                    w_pend_nx       = w_acc_req;
                end
                // The automatic fall starts a normal low-level dwell.
                if (w_tmr_done) begin
                    w_pin_nx   = 1'b0;
                    w_neg_nx   = 1'b1;
                    w_state_nx = c_st_hold;
                    w_tmr_load = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
`endif
            default: begin
                if (w_accept) begin
                    w_do_apply = 1'b1;
                end
            end
        endcase

        if (w_do_apply) begin
            w_state_nx  = c_st_stable;
            w_tmr_clear = 1'b1;
`ifdef OUTCOND_PULSE_EN
            if (w_src.pulse) begin
                if (!r_pin) begin
                    w_pin_nx    = 1'b1;
                    w_pos_nx    = 1'b1;
                    w_state_nx  = c_st_pulse;
                    w_tmr_clear = 1'b0;
                    w_tmr_load  = 1'b1;
                end
            end else
`endif
            if (w_src.level != r_pin) begin
                w_pin_nx    = w_src.level;
                w_pos_nx    = w_src.level;
                w_neg_nx    = !w_src.level;
                w_state_nx  = c_st_hold;
                w_tmr_clear = 1'b0;
                w_tmr_load  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_stable;
            r_pin        <= 1'b0;
            r_pos        <= 1'b0;
            r_neg        <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_pin        <= w_pin_nx;
            r_pos        <= w_pos_nx;
            r_neg        <= w_neg_nx;
            r_pend_valid <= w_pend_valid_nx;
            r_pend       <= w_pend_nx;
        end
    end

    assign pinout       = r_pin;
    assign positiveedge = r_pos;
    assign negativeedge = r_neg;
    assign busy         = (r_state != c_st_stable);

endmodule

`default_nettype wire

// File: tb/tb_output_conditioner.sv
// +----------------------------------------------------------------------------+
// | tb_output_conditioner                                                      |
// | Directed per-cycle vector table plus dwell and auto-pulse sequences.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_output_conditioner;

    localparam int c_hold = 3;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic req_valid = 1'b0;
    logic req_level = 1'b0;
    logic req_ready;
    logic pinout;
    logic positiveedge;
    logic negativeedge;
    logic busy;
`ifdef OUTCOND_PULSE_EN
    logic pulse_req = 1'b0;
`endif

    always #5 clk = ~clk;

    output_conditioner #(
        .COUNTERWIDTH (3),
        .HOLDTIME     (c_hold),
        .PULSEWIDTH   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_level    (req_level),
        .req_ready    (req_ready),
        .pinout       (pinout),
        .positiveedge (positiveedge),
        .negativeedge (negativeedge),
        .busy         (busy)
`ifdef OUTCOND_PULSE_EN
        ,
        .pulse_req    (pulse_req)
`endif
    );

    // exp packs {req_ready, pinout, positiveedge, negativeedge, busy}
    typedef struct packed {
        logic       rst;
        logic       valid;
        logic       level;
        logic [4:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic r, input logic v, input logic l, input logic [4:0] e);
        vq.push_back('{r, v, l, e});
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: rdy/pin/pe/ne/busy got %b required %b", name, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {req_ready, pinout, positiveedge, negativeedge, busy};
    endfunction

    task automatic step(input string name, input logic v, input logic l, input logic p,
                        input logic [4:0] exp);
        @(posedge clk);
        #1;
        req_valid = v;
        req_level = l;
`ifdef OUTCOND_PULSE_EN
        pulse_req = p;
`else
        if (p) $display("note: pulse request ignored in this build");
`endif
        @(negedge clk);
        check(name, outs(), exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;

        // reset and idle
        add(0,0,0,5'b10000); add(1,0,0,5'b10000);
        // single rise from STABLE
        add(1,1,1,5'b10000); add(1,0,0,5'b11101); add(1,0,0,5'b11001);
        add(1,0,0,5'b11001); add(1,0,0,5'b11000);
        // no-op request at current level 1
        add(1,1,1,5'b11000); add(1,0,0,5'b11000);
        // fall, then no-op level 0 while low
        add(1,1,0,5'b11000); add(1,0,0,5'b10011); add(1,0,0,5'b10001);
        add(1,0,0,5'b10001); add(1,0,0,5'b10000);
        add(1,1,0,5'b10000); add(1,0,0,5'b10000);
        // rise then pending fall
        add(1,1,1,5'b10000); add(1,1,0,5'b11101); add(1,0,0,5'b01001);
        add(1,0,0,5'b01001); add(1,0,0,5'b10011); add(1,0,0,5'b10001);
        add(1,0,0,5'b10001); add(1,0,0,5'b10000);
        // third request held while pending full
        add(1,1,1,5'b10000); add(1,1,0,5'b11101); add(1,1,1,5'b01001);
        add(1,1,1,5'b01001); add(1,1,1,5'b10011); add(1,0,0,5'b00001);
        add(1,0,0,5'b00001); add(1,0,0,5'b11101); add(1,0,0,5'b11001);
        add(1,0,0,5'b11001); add(1,0,0,5'b11000);
        // request arriving in the expiry cycle with pending empty
        add(1,1,0,5'b11000); add(1,0,0,5'b10011); add(1,0,0,5'b10001);
        add(1,1,1,5'b10001); add(1,0,0,5'b11101); add(1,0,0,5'b11001);
        add(1,0,0,5'b11001); add(1,0,0,5'b11000);
        // reset mid-HOLD with pending valid while pin is high
        add(1,1,0,5'b11000); add(1,1,1,5'b10011); add(1,0,0,5'b00001);
        add(1,0,0,5'b00001); add(1,0,0,5'b11101); add(1,1,0,5'b11001);
        add(0,0,0,5'b10000); add(0,0,0,5'b10000); add(1,0,0,5'b10000);
        add(1,0,0,5'b10000);
        add(1,1,1,5'b10000); add(1,0,0,5'b11101); add(1,0,0,5'b11001);
        add(1,0,0,5'b11001); add(1,0,0,5'b11000);

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            rst_n     = vq[i].rst;
            req_valid = vq[i].valid;
            req_level = vq[i].level;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), vq[i].exp);
        end

        // dwell length of a fall, bounded wait for busy to clear
        step("dwell_req",  1'b1, 1'b0, 1'b0, 5'b11000);
        step("dwell_fall", 1'b0, 1'b0, 1'b0, 5'b10011);
        busy_cnt = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != c_hold) begin
            n_fail++;
            $display("FAIL dwell_len: busy cycles got %0d required %0d", busy_cnt, c_hold);
        end

`ifdef OUTCOND_PULSE_EN
        // auto-pulse from low, then a level-1 request held off by the low dwell
        step("pls_c0", 1'b0, 1'b0, 1'b1, 5'b10000);
        step("pls_c1", 1'b0, 1'b0, 1'b0, 5'b11101);
        step("pls_c2", 1'b0, 1'b0, 1'b0, 5'b11001);
        step("pls_c3", 1'b0, 1'b0, 1'b0, 5'b11001);
        step("pls_c4", 1'b0, 1'b0, 1'b0, 5'b11001);
        step("pls_c5", 1'b1, 1'b1, 1'b0, 5'b10011);
        step("pls_c6", 1'b0, 1'b0, 1'b0, 5'b00001);
        step("pls_c7", 1'b0, 1'b0, 1'b0, 5'b00001);
        step("pls_c8", 1'b0, 1'b0, 1'b0, 5'b11101);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
